pwm_multi_chan: RTL

Parametrised N-channel PWM generator, successor to the fixed 3-channel 7-bit PWM block.
- One shared prescaler and period counter.
- Per-channel duty registers written through a simple write port, double-buffered so updates are glitch-free.
- Sits behind the tt_um top: ui_in/uio_in are decoded into the write port, and pwm_out drives uo_out.

---
 rtl/pwm_multi_chan.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_chan.sv
// pwm_multi_chan: N-channel PWM generator with a shared prescaler and period
// counter, and double-buffered per-channel duty registers.
// Optional feature macro: PWM_CENTER_ALIGN_EN adds the center_mode input,
// which selects up/down center-aligned counting.

// Per-channel slice: shadow/active duty pair plus registered compare output.
module pwm_multi_chan_lane #(
    parameter int   RES_BITS = 8,
    parameter logic POL      = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                period_end,
    input  logic                wr_hit,
    input  logic [RES_BITS-1:0] wr_duty,
    input  logic [RES_BITS-1:0] cmp_val,
    output logic                pwm
);
    logic [RES_BITS-1:0] shadow;
    logic [RES_BITS-1:0] active;

    // Shadow captures every write addressed to this channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      shadow <= '0;
        else if (wr_hit) shadow <= wr_duty;
    end

    // Active reloads at period end (a same-cycle write bypasses the shadow)
    // and tracks the shadow continuously while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          active <= '0;
        else if (period_end) active <= wr_hit ? wr_duty : shadow;
        else if (!en)        active <= shadow;
    end

    // Registered compare; disabled output parks at the inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pwm <= POL;
        else if (!en) pwm <= POL;
        else          pwm <= (cmp_val < active) ^ POL;
    end
endmodule

// Top: shared timebase and per-channel lanes.
module pwm_multi_chan #(
    parameter int                NUM_CH   = 4,
    parameter int                RES_BITS = 8,
    parameter int                PRESC_W  = 16,
    parameter logic [NUM_CH-1:0] POL_MASK = '0,
    localparam int               WR_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                center_mode,
`endif
    input  logic                en,
    input  logic [PRESC_W-1:0]  prescale_div,
    input  logic [RES_BITS-1:0] period,
    input  logic                wr_en,
    input  logic [WR_CH_W-1:0]  wr_ch,
    input  logic [RES_BITS-1:0] wr_duty,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                period_pulse
);
    logic [PRESC_W-1:0]  pre_cnt;
    logic [RES_BITS-1:0] cnt;
    logic [RES_BITS-1:0] period_act;
    logic [RES_BITS-1:0] cmp_val;
    logic                tick;
    logic                period_end;

    assign tick = en && (pre_cnt == prescale_div);

    // Prescaler: 0..prescale_div, held at 0 while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pre_cnt <= '0;
        else if (!en || tick) pre_cnt <= '0;
        else                  pre_cnt <= pre_cnt + PRESC_W'(1);
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic center_act;
    logic dir_down;

    assign period_end = tick && (center_act ? (dir_down && (cnt == '0))
                                            : (cnt == period_act));
    // Compare against distance from the peak so the pulse is centred on it
    assign cmp_val    = center_act ? (period_act - cnt) : cnt;

    // Mode is only allowed to change on a period boundary or while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 center_act <= 1'b0;
        else if (!en || period_end) center_act <= center_mode;
    end

    // Up/down counter; each end value is held one extra tick by flipping
    // direction without moving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (!en) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (tick) begin
            if (!center_act) begin
                cnt      <= (cnt == period_act) ? '0 : cnt + RES_BITS'(1);
                dir_down <= 1'b0;
            end else if (!dir_down) begin
                if (cnt == period_act) dir_down <= 1'b1;
                else                   cnt      <= cnt + RES_BITS'(1);
            end else begin
                if (cnt == '0) dir_down <= 1'b0;
                else           cnt      <= cnt - RES_BITS'(1);
            end
        end
    end
`else
    assign period_end = tick && (cnt == period_act);
    assign cmp_val    = cnt;

    // Edge-aligned counter: 0..period_act on ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (!en)        cnt <= '0;
        else if (period_end) cnt <= '0;
        else if (tick)       cnt <= cnt + RES_BITS'(1);
    end
`endif

    // Period terminal value only changes on a boundary or while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 period_act <= '0;
        else if (!en || period_end) period_act <= period;
    end

    // One-clock pulse marking each period end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) period_pulse <= 1'b0;
        else        period_pulse <= period_end;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        pwm_multi_chan_lane #(
            .RES_BITS (RES_BITS),
            .POL      (POL_MASK[g])
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .period_end (period_end),
            .wr_hit     (wr_en && (wr_ch == WR_CH_W'(g))),
            .wr_duty    (wr_duty),
            .cmp_val    (cmp_val),
            .pwm        (pwm_out[g])
        );
    end
endmodule
